// File: rtl/fft_pair_buffer_if.sv
// rtl/fft_pair_buffer_if.sv - sample stream in / butterfly operand pair out bundle
//
// Ports (slave = the buffer, master = the upstream source / downstream consumer side):
//   in_valid, in_sync        sample qualifier and frame-start marker
//   in_re, in_im             signed input sample
//   out_valid, out_last      operand pair strobe, last pair of the frame
//   out_r_lo, out_i_lo       x[k]
//   out_r_hi, out_i_hi       x[k+N/2]
//   out_k                    pair index

interface fft_pair_buffer_if #(
    parameter int DATA_W = 8,
    parameter int N      = 16
);
    localparam int K_W = $clog2(N) - 1;

    logic                     in_valid;
    logic                     in_sync;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;

    logic                     out_valid;
    logic signed [DATA_W-1:0] out_r_lo;
    logic signed [DATA_W-1:0] out_r_hi;
    logic signed [DATA_W-1:0] out_i_lo;
    logic signed [DATA_W-1:0] out_i_hi;
    logic [K_W-1:0]           out_k;
    logic                     out_last;

    modport master (
        output in_valid, in_sync, in_re, in_im,
        input  out_valid, out_r_lo, out_r_hi, out_i_lo, out_i_hi, out_k, out_last
    );

    modport slave (
        input  in_valid, in_sync, in_re, in_im,
        output out_valid, out_r_lo, out_r_hi, out_i_lo, out_i_hi, out_k, out_last
    );
endinterface

// File: rtl/fft_pair_buffer.sv
// rtl/fft_pair_buffer.sv - natural-order sample stream to radix-2 butterfly operand pairs
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     fft_pair_buffer_if.slave: in_valid/in_sync/in_re/in_im in,
//           out_valid/out_r_lo/out_r_hi/out_i_lo/out_i_hi/out_k/out_last out
//
// The first N/2 samples of a frame are parked in pair_mem; each second-half
// sample x[k+N/2] is registered out together with x[k] one cycle later.

module fft_pair_buffer #(
    parameter int DATA_W = 8,
    parameter int N      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_pair_buffer_if.slave  bus
);
    localparam int IDX_W = $clog2(N);
    localparam int K_W   = IDX_W - 1;
    localparam int HALF  = N / 2;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_r_lo_q, out_r_lo_d;
    logic signed [DATA_W-1:0] out_r_hi_q, out_r_hi_d;
    logic signed [DATA_W-1:0] out_i_lo_q, out_i_lo_d;
    logic signed [DATA_W-1:0] out_i_hi_q, out_i_hi_d;
    logic [K_W-1:0]           out_k_q, out_k_d;
    logic                     out_last_q, out_last_d;

    logic [2*DATA_W-1:0]      pair_mem [HALF];
    logic [IDX_W-1:0]         eff_idx;
    logic                     in_pair;
    logic                     mem_we;
    logic [K_W-1:0]           mem_addr;
    logic [2*DATA_W-1:0]      mem_rdata;

    always_comb begin
        // A sync sample is frame index 0 regardless of where the counter was,
        // which is what discards a partial frame.
        eff_idx   = bus.in_sync ? '0 : idx_q;
        in_pair   = eff_idx[IDX_W-1];
        // FILL writes buf[e] and PAIR reads buf[e-N/2]; both are the low bits
        // of e, so the single port needs just one address.
        mem_addr  = eff_idx[K_W-1:0];
        mem_rdata = pair_mem[mem_addr];
        mem_we    = bus.in_valid & ~in_pair;

        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_r_lo_d  = out_r_lo_q;
        out_r_hi_d  = out_r_hi_q;
        out_i_lo_d  = out_i_lo_q;
        out_i_hi_d  = out_i_hi_q;
        out_k_d     = out_k_q;

        if (bus.in_valid) begin
            idx_d = eff_idx + IDX_ONE;
            if (in_pair) begin
                out_valid_d = 1'b1;
                out_r_lo_d  = mem_rdata[2*DATA_W-1:DATA_W];
                out_i_lo_d  = mem_rdata[DATA_W-1:0];
                out_r_hi_d  = bus.in_re;
                out_i_hi_d  = bus.in_im;
                out_k_d     = mem_addr;
                out_last_d  = &mem_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_r_lo_q  <= '0;
            out_r_hi_q  <= '0;
            out_i_lo_q  <= '0;
            out_i_hi_q  <= '0;
            out_k_q     <= '0;
            out_last_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_r_lo_q  <= out_r_lo_d;
            out_r_hi_q  <= out_r_hi_d;
            out_i_lo_q  <= out_i_lo_d;
            out_i_hi_q  <= out_i_hi_d;
            out_k_q     <= out_k_d;
            out_last_q  <= out_last_d;
        end
    end

    // Buffer contents need no reset: every entry is written in FILL before
    // the PAIR phase of the same frame can read it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            pair_mem[mem_addr] <= {bus.in_re, bus.in_im};
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_r_lo  = out_r_lo_q;
    assign bus.out_r_hi  = out_r_hi_q;
    assign bus.out_i_lo  = out_i_lo_q;
    assign bus.out_i_hi  = out_i_hi_q;
    assign bus.out_k     = out_k_q;
    assign bus.out_last  = out_last_q;

endmodule
